// File: rtl/tag_lookup_ctrl_pkg.sv
// Shared widths, state encoding and entry layout for the tag lookup controller.
package tag_ctrl_pkg;

    localparam int unsigned AWIDTH    = 3;
    localparam int unsigned DWIDTH    = 14;
    localparam int unsigned TWIDTH    = DWIDTH - 1;
    localparam int unsigned DEPTH     = 1 << AWIDTH;
    localparam int unsigned CWIDTH    = AWIDTH + 1;
    localparam int unsigned VALID_BIT = DWIDTH - 1;
    localparam int unsigned TAG_MSB   = DWIDTH - 2;

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        IDLE  = 3'd1,
        ISSUE = 3'd2,
        CMP   = 3'd3,
        RESP  = 3'd4
    } state_e;

    // One tag RAM entry: valid flag above the stored tag.
    typedef struct packed {
        logic              valid;
        logic [TWIDTH-1:0] tag;
    } entry_t;

    // Build a RAM entry from its fields.
    function automatic entry_t pack_entry(input logic valid, input logic [TWIDTH-1:0] tag);
        entry_t e;
        e.valid = valid;
        e.tag   = tag;
        return e;
    endfunction

endpackage

// File: rtl/tag_lookup_ctrl_if.sv
// Request/response handshake between a requester and the tag lookup controller.
interface tag_lookup_ctrl_if;
    import tag_ctrl_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_fill;
    logic [AWIDTH-1:0] req_index;
    logic [TWIDTH-1:0] req_tag;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_hit;
    logic              rsp_fill;

    modport master (
        output req_valid, req_fill, req_index, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_hit, rsp_fill
    );

    modport slave (
        input  req_valid, req_fill, req_index, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_hit, rsp_fill
    );

endinterface

// File: rtl/tag_init_sweep.sv
// Post-reset clear sweep: walks every index once, then latches the done flag.
module tag_init_sweep
    import tag_ctrl_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              en_i,
    output logic [AWIDTH-1:0] addr_o,
    output logic              last_c,
    output logic              init_done_o
);

    logic [CWIDTH-1:0] cnt_q, cnt_d;
    logic              done_q, done_d;

    assign addr_o      = cnt_q[AWIDTH-1:0];
    assign last_c      = en_i && (cnt_q == CWIDTH'(DEPTH));
    assign init_done_o = done_q;

    // Counter and done flag registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    // Advance while sweeping; the counter parks at DEPTH once the sweep ends.
    always_comb begin
        cnt_d  = cnt_q;
        done_d = done_q;
        if (en_i) begin
            if (cnt_q == CWIDTH'(DEPTH)) begin
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CWIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/tag_sync_ram.sv
// Single-port tag RAM: address registered on the clock, read data is mem[latched address].
module tag_sync_ram
    import tag_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic [AWIDTH-1:0] addr_i,
    input  logic [DWIDTH-1:0] din_i,
    input  logic              we_i,
    output logic [DWIDTH-1:0] dout_o
);

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [AWIDTH-1:0] addr_q;

    // Write port and address latch share the same edge.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= din_i;
        end
        addr_q <= addr_i;
    end

    assign dout_o = mem_q[addr_q];

endmodule

// File: rtl/tag_lookup_ctrl.sv
// Tag RAM requester: clears the RAM after reset, then serves one lookup/fill at a time.
module tag_lookup_ctrl
    import tag_ctrl_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    tag_lookup_ctrl_if.slave   bus,
    output logic               init_done,
    output logic [AWIDTH-1:0]  ram_addr,
    output logic [DWIDTH-1:0]  ram_din,
    output logic               ram_we,
    input  logic [DWIDTH-1:0]  ram_dout
);

    state_e            state_q, state_d;
    logic [AWIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DWIDTH-1:0] ram_din_q, ram_din_d;
    logic              ram_we_q, ram_we_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_hit_q, rsp_hit_d;
    logic              rsp_fill_q, rsp_fill_d;
    logic [TWIDTH-1:0] tag_q, tag_d;
    logic              fill_q, fill_d;

    logic [AWIDTH-1:0] sweep_addr;
    logic              sweep_last_c;
    logic              req_ready_c;
    entry_t            rd_entry;

    tag_init_sweep u_sweep (
        .clock       (clock),
        .reset_n     (reset_n),
        .en_i        (state_q == INIT),
        .addr_o      (sweep_addr),
        .last_c      (sweep_last_c),
        .init_done_o (init_done)
    );

    assign req_ready_c   = (state_q == IDLE);
    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_hit   = rsp_hit_q;
    assign bus.rsp_fill  = rsp_fill_q;
    assign ram_addr      = ram_addr_q;
    assign ram_din       = ram_din_q;
    assign ram_we        = ram_we_q;
    assign rd_entry      = entry_t'(ram_dout);

    // State and registered output flops.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= INIT;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            ram_we_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_fill_q  <= 1'b0;
            tag_q       <= '0;
            fill_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ram_addr_q  <= ram_addr_d;
            ram_din_q   <= ram_din_d;
            ram_we_q    <= ram_we_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_fill_q  <= rsp_fill_d;
            tag_q       <= tag_d;
            fill_q      <= fill_d;
        end
    end

    // Next state, RAM pin drive and response compare.
    always_comb begin
        state_d     = state_q;
        ram_addr_d  = ram_addr_q;
        ram_din_d   = ram_din_q;
        ram_we_d    = ram_we_q;
        rsp_valid_d = rsp_valid_q;
        rsp_hit_d   = rsp_hit_q;
        rsp_fill_d  = rsp_fill_q;
        tag_d       = tag_q;
        fill_d      = fill_q;

        case (state_q)
            INIT: begin
                if (sweep_last_c) begin
                    ram_we_d = 1'b0;
                    state_d  = IDLE;
                end else begin
                    ram_addr_d = sweep_addr;
                    ram_din_d  = '0;
                    ram_we_d   = 1'b1;
                end
            end
            IDLE: begin
                ram_we_d = 1'b0;
                if (bus.req_valid && req_ready_c) begin
                    tag_d      = bus.req_tag;
                    fill_d     = bus.req_fill;
                    ram_addr_d = bus.req_index;
                    ram_we_d   = bus.req_fill;
                    ram_din_d  = pack_entry(1'b1, bus.req_tag);
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                // RAM latches the address (and writes) on this edge.
                ram_we_d = 1'b0;
                state_d  = CMP;
            end
            CMP: begin
                // Read data now reflects the entry, including a fill just written.
                rsp_hit_d   = rd_entry.valid && (rd_entry.tag == tag_q);
                rsp_fill_d  = fill_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

endmodule

// File: tb/tb_tag_lookup_ctrl.sv
// Self-checking bench for tag_lookup_ctrl with a scoreboard of expected responses.
module tb_tag_lookup_ctrl;
    import tag_ctrl_pkg::*;

    logic              clock = 1'b0;
    logic              reset_n = 1'b1;
    logic [AWIDTH-1:0] ram_addr;
    logic [DWIDTH-1:0] ram_din;
    logic [DWIDTH-1:0] ram_dout;
    logic              ram_we;
    logic              init_done;

    tag_lookup_ctrl_if bus();

    tag_lookup_ctrl dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus       (bus),
        .init_done (init_done),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_we    (ram_we),
        .ram_dout  (ram_dout)
    );

    tag_sync_ram u_ram (
        .clk    (clock),
        .addr_i (ram_addr),
        .din_i  (ram_din),
        .we_i   (ram_we),
        .dout_o (ram_dout)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic hit;
        logic fill;
    } exp_t;

    exp_t              sb[$];
    logic              model_v [DEPTH];
    logic [TWIDTH-1:0] model_t [DEPTH];
    int                total = 0;
    int                bad = 0;

    // Reference behaviour: fills always read back as hits; lookups compare against the model.
    function automatic exp_t predict(input logic fill, input logic [AWIDTH-1:0] idx,
                                     input logic [TWIDTH-1:0] tag);
        exp_t e;
        e.fill = fill;
        if (fill) begin
            model_v[idx] = 1'b1;
            model_t[idx] = tag;
            e.hit = 1'b1;
        end else begin
            e.hit = model_v[idx] && (model_t[idx] == tag);
        end
        return e;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < int'(DEPTH); i++) begin
            model_v[i] = 1'b0;
            model_t[i] = '0;
        end
    endtask

    // Called just after a falling edge; returns at the falling edge where rsp_valid is seen.
    task automatic drive_req(input logic fill, input logic [AWIDTH-1:0] idx,
                             input logic [TWIDTH-1:0] tag, output int lat, output exp_t got,
                             output int we_pulses, output logic [DWIDTH-1:0] din_seen,
                             output logic tmo);
        int n;
        lat = 0;
        got = '0;
        we_pulses = 0;
        din_seen = '0;
        tmo = 1'b0;
        sb.push_back(predict(fill, idx, tag));
        bus.req_valid = 1'b1;
        bus.req_fill  = fill;
        bus.req_index = idx;
        bus.req_tag   = tag;
        n = 0;
        while (!bus.req_ready && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (!bus.req_ready) begin
            tmo = 1'b1;
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clock);
        @(negedge clock);
        bus.req_valid = 1'b0;
        while (!bus.rsp_valid && lat < 20) begin
            if (ram_we) begin
                we_pulses++;
                din_seen = ram_din;
            end
            @(negedge clock);
            lat++;
        end
        tmo = !bus.rsp_valid;
        got.hit  = bus.rsp_hit;
        got.fill = bus.rsp_fill;
    endtask

    task automatic finish_rsp();
        bus.rsp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset(input string name);
        reset_n = 1'b0;
        #1;
        model_clear();
        total++;
        if ({ram_we, ram_addr, ram_din, init_done, bus.rsp_valid, bus.rsp_hit, bus.rsp_fill,
             bus.req_ready} !== '0)
            begin bad++; $display("FAIL %s_reset_vals got we=%b addr=%0d din=%h done=%b rv=%b rh=%b rf=%b rdy=%b want all 0",
                name, ram_we, ram_addr, ram_din, init_done, bus.rsp_valid, bus.rsp_hit, bus.rsp_fill, bus.req_ready); end
        repeat (2) @(negedge clock);
        total++;
        if (bus.rsp_valid !== 1'b0 || ram_we !== 1'b0)
            begin bad++; $display("FAIL %s_reset_hold got rv=%b we=%b want 0 0", name, bus.rsp_valid, ram_we); end
        reset_n = 1'b1;
        for (int k = 0; k < int'(DEPTH); k++) begin
            @(negedge clock);
            total++;
            if (ram_we !== 1'b1 || ram_addr !== AWIDTH'(k) || ram_din !== '0 || init_done !== 1'b0)
                begin bad++; $display("FAIL %s_sweep%0d got we=%b addr=%0d din=%h done=%b want we=1 addr=%0d din=0 done=0",
                    name, k, ram_we, ram_addr, ram_din, init_done, k); end
        end
        @(negedge clock);
        total++;
        if (ram_we !== 1'b0 || init_done !== 1'b1 || bus.req_ready !== 1'b1)
            begin bad++; $display("FAIL %s_sweep_end got we=%b done=%b rdy=%b want 0 1 1",
                name, ram_we, init_done, bus.req_ready); end
    endtask

    task automatic test_lookup_miss();
        int lat, wp;
        exp_t got, e;
        logic [DWIDTH-1:0] din;
        logic tmo;
        drive_req(1'b0, 3'd5, 13'h0ABC, lat, got, wp, din, tmo);
        e = sb.pop_front();
        total++;
        if (tmo !== 1'b0 || lat !== 2)
            begin bad++; $display("FAIL lookup_latency got lat=%0d tmo=%b want 2 0", lat, tmo); end
        total++;
        if (got !== e || got !== 2'b00)
            begin bad++; $display("FAIL lookup_rsp got hit=%b fill=%b want hit=%b fill=%b", got.hit, got.fill, e.hit, e.fill); end
        total++;
        if (wp !== 0)
            begin bad++; $display("FAIL lookup_we got pulses=%0d want 0", wp); end
        finish_rsp();
        total++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1)
            begin bad++; $display("FAIL lookup_release got rv=%b rdy=%b want 0 1", bus.rsp_valid, bus.req_ready); end
    endtask

    task automatic test_fill();
        int lat, wp;
        exp_t got, e;
        logic [DWIDTH-1:0] din;
        logic tmo;
        logic [TWIDTH-1:0] tags [2];
        tags = '{13'h0ABC, 13'h0ABD};
        drive_req(1'b1, 3'd5, 13'h0ABC, lat, got, wp, din, tmo);
        e = sb.pop_front();
        total++;
        if (tmo !== 1'b0 || lat !== 2 || wp !== 1 || din !== 14'h2ABC)
            begin bad++; $display("FAIL fill_write got lat=%0d pulses=%0d din=%h tmo=%b want 2 1 2abc 0", lat, wp, din, tmo); end
        total++;
        if (got !== e || got !== 2'b11)
            begin bad++; $display("FAIL fill_rsp got hit=%b fill=%b want 1 1", got.hit, got.fill); end
        finish_rsp();
        for (int i = 0; i < 2; i++) begin
            drive_req(1'b0, 3'd5, tags[i], lat, got, wp, din, tmo);
            e = sb.pop_front();
            total++;
            if (tmo !== 1'b0 || got !== e || wp !== 0)
                begin bad++; $display("FAIL fill_lookup%0d got hit=%b fill=%b pulses=%0d tmo=%b want hit=%b fill=%b pulses=0",
                    i, got.hit, got.fill, wp, tmo, e.hit, e.fill); end
            finish_rsp();
        end
    endtask

    task automatic test_backpressure();
        int lat, wp;
        exp_t got, e;
        logic [DWIDTH-1:0] din;
        logic tmo;
        drive_req(1'b0, 3'd5, 13'h0ABC, lat, got, wp, din, tmo);
        e = sb.pop_front();
        total++;
        if (tmo !== 1'b0 || got !== e)
            begin bad++; $display("FAIL bp_first got hit=%b tmo=%b want hit=%b", got.hit, tmo, e.hit); end
        bus.req_valid = 1'b1;
        bus.req_fill  = 1'b0;
        bus.req_index = 3'd5;
        bus.req_tag   = 13'h0ABD;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            total++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_hit !== e.hit || bus.rsp_fill !== 1'b0 ||
                bus.req_ready !== 1'b0 || ram_we !== 1'b0)
                begin bad++; $display("FAIL bp_hold%0d got rv=%b rh=%b rf=%b rdy=%b we=%b want 1 %b 0 0 0",
                    i, bus.rsp_valid, bus.rsp_hit, bus.rsp_fill, bus.req_ready, ram_we, e.hit); end
        end
        finish_rsp();
        total++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1)
            begin bad++; $display("FAIL bp_release got rv=%b rdy=%b want 0 1", bus.rsp_valid, bus.req_ready); end
        drive_req(1'b0, 3'd5, 13'h0ABD, lat, got, wp, din, tmo);
        e = sb.pop_front();
        total++;
        if (tmo !== 1'b0 || lat !== 2 || got !== e)
            begin bad++; $display("FAIL bp_second got hit=%b lat=%0d tmo=%b want hit=%b lat=2", got.hit, lat, tmo, e.hit); end
        finish_rsp();
    endtask

    task automatic test_back_to_back();
        int accepts = 0;
        exp_t e;
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_fill  = 1'b0;
        bus.req_index = 3'd5;
        bus.req_tag   = 13'h0ABC;
        for (int n = 0; n < 12; n++) begin
            if (bus.rsp_valid) begin
                e = sb.pop_front();
                total++;
                if ({bus.rsp_hit, bus.rsp_fill} !== e)
                    begin bad++; $display("FAIL b2b_rsp%0d got hit=%b fill=%b want %b %b", n, bus.rsp_hit, bus.rsp_fill, e.hit, e.fill); end
            end
            if (bus.req_ready) begin
                sb.push_back(predict(1'b0, 3'd5, 13'h0ABC));
                accepts++;
            end
            @(negedge clock);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        total++;
        if (accepts !== 3 || sb.size() !== 0)
            begin bad++; $display("FAIL b2b_rate got accepts=%0d pending=%0d want 3 0", accepts, sb.size()); end
    endtask

    task automatic test_wrap();
        int lat, wp;
        exp_t got, e;
        logic [DWIDTH-1:0] din;
        logic tmo;
        logic              f   [6];
        logic [AWIDTH-1:0] idx [6];
        logic [TWIDTH-1:0] tg  [6];
        logic              want [6];
        f    = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        idx  = '{3'd7, 3'd0, 3'd7, 3'd0, 3'd7, 3'd0};
        tg   = '{13'h1FFF, 13'h0001, 13'h1FFF, 13'h0001, 13'h0001, 13'h1FFF};
        want = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            drive_req(f[i], idx[i], tg[i], lat, got, wp, din, tmo);
            e = sb.pop_front();
            total++;
            if (tmo !== 1'b0 || got !== e || got.hit !== want[i] || got.fill !== f[i])
                begin bad++; $display("FAIL wrap%0d idx=%0d tag=%h got hit=%b fill=%b tmo=%b want hit=%b fill=%b",
                    i, idx[i], tg[i], got.hit, got.fill, tmo, want[i], f[i]); end
            finish_rsp();
        end
    endtask

    task automatic test_reset_midflight();
        int n, lat, wp;
        exp_t got, e;
        logic [DWIDTH-1:0] din;
        logic tmo;
        bus.req_valid = 1'b1;
        bus.req_fill  = 1'b1;
        bus.req_index = 3'd2;
        bus.req_tag   = 13'h0123;
        n = 0;
        while (!bus.req_ready && n < 40) begin
            @(negedge clock);
            n++;
        end
        total++;
        if (bus.req_ready !== 1'b1)
            begin bad++; $display("FAIL midrst_accept got rdy=%b want 1", bus.req_ready); end
        @(posedge clock);
        @(negedge clock);
        bus.req_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        test_reset("midrst");
        drive_req(1'b0, 3'd2, 13'h0123, lat, got, wp, din, tmo);
        e = sb.pop_front();
        total++;
        if (tmo !== 1'b0 || got !== e || got.hit !== 1'b0)
            begin bad++; $display("FAIL midrst_lookup got hit=%b tmo=%b want hit=0", got.hit, tmo); end
        finish_rsp();
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_fill  = 1'b0;
        bus.req_index = '0;
        bus.req_tag   = '0;
        bus.rsp_ready = 1'b0;
        model_clear();
        #1;
        test_reset("por");
        test_lookup_miss();
        test_fill();
        test_backpressure();
        test_back_to_back();
        test_wrap();
        test_reset_midflight();
        total++;
        if (sb.size() !== 0)
            begin bad++; $display("FAIL sb_drain got pending=%0d want 0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tag_lookup_ctrl.md
# tag_lookup_ctrl

Controller on the requester side of the single-port, synchronous-read tag RAM. It clears every tag entry after reset. It then accepts one lookup or fill request at a time, drives the RAM address, write-enable and write-data pins, and compares the read-back entry against the requested tag. A hit/miss response is returned over a valid/ready handshake.

## Interface
- AWIDTH, 3: index width; RAM depth DEPTH = 1 << AWIDTH
- DWIDTH, 14: RAM entry width; bit DWIDTH-1 = valid, bits DWIDTH-2:0 = tag (TWIDTH = DWIDTH-1)

One clock; reset is asynchronous and active-low.

- clock  in  1  rising-edge clock, shared with the RAM
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_fill  in  1  1 = fill (write tag), 0 = lookup
- req_index  in  AWIDTH  entry index
- req_tag  in  TWIDTH  tag to write or compare
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes the response
- rsp_hit  out  1  read-back entry is valid and its tag equals the request tag
- rsp_fill  out  1  echo of req_fill
- init_done  out  1  clear sweep finished
- ram_addr  out  AWIDTH  RAM address
- ram_din  out  DWIDTH  RAM write data
- ram_we  out  1  RAM write enable
- ram_dout  in  DWIDTH  RAM read data; the RAM registers the address and returns mem[latched address]

## Operation
- Registered outputs: ram_addr, ram_din, ram_we, rsp_valid, rsp_hit, rsp_fill, init_done.
- Reset values: all registered outputs are 0; state = INIT; sweep counter = 0.
- req_ready is combinational and equals (state == IDLE).
- States and transitions:
  - INIT: each edge sets ram_addr <= cnt, ram_we <= 1, ram_din <= 0, cnt <= cnt + 1. The counter is AWIDTH+1 bits wide. On the edge where cnt == DEPTH, the block sets ram_we <= 0 and init_done <= 1, and moves to IDLE.
  - IDLE: on req_valid && req_ready, the block captures the tag and fill flag. It sets ram_addr <= req_index, ram_we <= req_fill and ram_din <= {1'b1, req_tag}, and moves to ISSUE. Without a request it stays in IDLE and ram_we stays 0.
  - ISSUE: the RAM latches the address and performs the write if ram_we is set. The block sets ram_we <= 0 and moves to CMP.
  - CMP: ram_dout holds the entry, which for a fill is the newly written value. The block sets rsp_hit <= ram_dout[DWIDTH-1] && (ram_dout[DWIDTH-2:0] == captured tag), rsp_fill <= captured fill flag and rsp_valid <= 1, and moves to RESP.
  - RESP: rsp_valid, rsp_hit and rsp_fill are held stable. On rsp_ready, rsp_valid <= 0 and the block returns to IDLE. The next request can be accepted on the following edge.
- A fill always reports rsp_hit = 1 (read-back check). rsp_hit = 0 after a fill indicates a RAM fault.
- req_valid is ignored outside IDLE. A requester may hold it asserted without effect.
- Index wrap: the index is used as is, with no offset arithmetic. The sweep covers 0..DEPTH-1 exactly once.
- Reset asserted in any state immediately forces the reset values. Any in-flight request is dropped with no response. After release the sweep reruns and all prior fills are lost.

## Timing
- Sweep: write pulses follow edges 1..DEPTH after reset release. init_done rises after edge DEPTH+1. The first accept can occur at edge DEPTH+2.
- Request accepted at edge E0: ram_addr is valid after E0, the RAM latches the address and performs any write at E1, and rsp_valid rises after E2.
- Minimum request period is 4 cycles when rsp_ready is held high.
- ram_we is high for exactly one cycle per fill and never high outside INIT or ISSUE.

## Structure
- Package tag_ctrl_pkg holds:
  - the state encoding (INIT, IDLE, ISSUE, CMP, RESP);
  - field constants VALID_BIT = DWIDTH-1 and TAG_MSB = DWIDTH-2;
  - a function that packs {valid, tag} into an entry.
- Optional sub-module tag_init_sweep contains the INIT counter and the done flag. The FSM and compare logic stay in the top module.
- The bench instantiates the team's synchronous-read RAM with AWIDTH=3 and DWIDTH=14 and connects it to the ram_* ports.

## Test plan
- Reset release, AWIDTH=3: ram_we is high for 8 cycles with ram_addr 0..7 and ram_din 0. init_done and req_ready go high after edge 9.
- Lookup index 5, tag 0x0ABC after init: rsp_valid rises 2 cycles after accept with rsp_hit=0 and rsp_fill=0.
- Fill index 5, tag 0x0ABC: ram_din=0x2ABC with a one-cycle ram_we, then rsp_hit=1 and rsp_fill=1. A following lookup of tag 0x0ABC returns hit=1. A lookup of tag 0x0ABD returns hit=0.
- rsp_ready held low for 5 cycles in RESP: rsp_valid and rsp_hit stay stable and req_ready stays 0. A concurrent req_valid is ignored; the accept happens only after the handshake.
- Fill index 7 with tag 0x1FFF and fill index 0 with tag 0x0001: lookups of both hit and swapped tags miss, showing no aliasing at the index wrap.
- reset_n pulsed low during CMP of a fill to index 2: rsp_valid stays 0, outputs go to reset values immediately, the 8-cycle sweep reruns, and a lookup of index 2 misses.
